logic_cell_lutk: RTL and testbench

Parametrised K-input fabric logic cell: a LUT with 2^K truth-table bits, an optional output flip-flop, and a configuration shift chain clocked by the fabric clock. It generalises the fixed 2-input cell to any K and adds three things: a configuration-complete flag, a programmable flip-flop initial value, and output suppression while configuration is in progress. Cells are tiled in the fabric top level and daisy-chained through `cfg_data_i` → `cfg_data_o`.

---
 rtl/logic_cell_lutk.sv | 103 ++++++++++
 tb/tb_logic_cell_lutk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_cell_lutk.sv
// K-input LUT logic cell with optional output flip-flop and serial configuration chain.
// Optional synchronous set/reset port sr_i is compiled in with LOGIC_CELL_SR_EN.
module logic_cell_lutk #(
    parameter int unsigned K        = 4,
    parameter int unsigned CFG_BITS = (1 << K) + 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [K-1:0] in_i,
    input  logic         ce_i,
    input  logic         cfg_en_i,
    input  logic         cfg_data_i,
`ifdef LOGIC_CELL_SR_EN
    input  logic         sr_i,
`endif
    output logic         cfg_data_o,
    output logic         cfg_done_o,
    output logic         out_o
);

    localparam int unsigned TtBits = 1 << K;
    localparam int unsigned CntW   = $clog2(CFG_BITS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg_sr_q, cfg_sr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                cfg_en_q;
    logic                ff_q, ff_d;

    logic [TtBits-1:0]   truth_table;
    logic                lut_out;
    logic                reg_sel;
    logic                ff_init;
    logic                cfg_fall;
    logic                sr_hit;

    assign truth_table = cfg_sr_q[TtBits-1:0];
    assign lut_out     = truth_table[in_i];
    assign reg_sel     = cfg_sr_q[TtBits];
    assign ff_init     = cfg_sr_q[TtBits+1];
    assign cfg_fall    = cfg_en_q & ~cfg_en_i;

`ifdef LOGIC_CELL_SR_EN
    assign sr_hit = sr_i;
`else
    assign sr_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_sr_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            cfg_en_q <= 1'b0;
            ff_q     <= 1'b0;
        end else begin
            cfg_sr_q <= cfg_sr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            cfg_en_q <= cfg_en_i;
            ff_q     <= ff_d;
        end
    end

    always_comb begin
        cfg_sr_d = cfg_sr_q;
        cnt_d    = cnt_q;
        if (cfg_en_i) begin
            cfg_sr_d = {cfg_sr_q[CFG_BITS-2:0], cfg_data_i};
            // Saturate so pass-through shifting for downstream cells keeps done high.
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        done_d = (cnt_d == CntMax);
    end

    always_comb begin
        ff_d = ff_q;
        if (cfg_en_i) begin
            ff_d = ff_q;
        end else if (cfg_fall) begin
            ff_d = ff_init;
        end else if (sr_hit) begin
            ff_d = ff_init;
        end else if (ce_i) begin
            ff_d = lut_out;
        end
    end

    // Output is masked combinationally while a (re)configuration is in progress.
    always_comb begin
        out_o = 1'b0;
        if (!cfg_en_i && done_q) begin
            out_o = reg_sel ? ff_q : lut_out;
        end
    end

    assign cfg_data_o = cfg_sr_q[CFG_BITS-1];
    assign cfg_done_o = done_q;

endmodule

// File: tb/tb_logic_cell_lutk.sv
// Scoreboard bench: two chained K=4 cells against a queue-based reference model.
module tb_logic_cell_lutk;

    localparam int NBITS = 18;

    logic       clk_i;
    logic       rst_n_i;
    logic [3:0] in_i;
    logic       ce_i;
    logic       cfg_en_i;
    logic       cfg_data_i;
    logic       sr_i;
    logic       a_dout, a_done, a_out;
    logic       b_dout, b_done, b_out;
    bit         clk_run;

    int checks;
    int errors;

    logic_cell_lutk #(.K(4)) u_a (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_i       (in_i),
        .ce_i       (ce_i),
        .cfg_en_i   (cfg_en_i),
        .cfg_data_i (cfg_data_i),
`ifdef LOGIC_CELL_SR_EN
        .sr_i       (sr_i),
`endif
        .cfg_data_o (a_dout),
        .cfg_done_o (a_done),
        .out_o      (a_out)
    );

    logic_cell_lutk #(.K(4)) u_b (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_i       (in_i),
        .ce_i       (ce_i),
        .cfg_en_i   (cfg_en_i),
        .cfg_data_i (a_dout),
`ifdef LOGIC_CELL_SR_EN
        .sr_i       (sr_i),
`endif
        .cfg_data_o (b_dout),
        .cfg_done_o (b_done),
        .out_o      (b_out)
    );

    initial begin
        clk_i = 1'b0;
        wait (clk_run);
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: each cell keeps the last 18 bits it received, newest at index 0,
    // so entry i is configuration bit i (table bits 0..15, reg_sel 16, ff_init 17).
    bit q0[$];
    bit q1[$];
    int cnt_m[2];
    bit ff_m[2];
    bit prev_en;

    typedef struct packed {
        bit o0; bit d0; bit c0;
        bit o1; bit d1; bit c1;
    } exp_t;
    exp_t sb[$];

    function automatic bit cbit(int c, int i);
        if (c == 0) return (i < q0.size()) ? q0[i] : 1'b0;
        return (i < q1.size()) ? q1[i] : 1'b0;
    endfunction

    function automatic bit exp_out(int c, logic [3:0] in, bit en);
        bit lut;
        lut = cbit(c, int'(in));
        if (en || cnt_m[c] < NBITS) return 1'b0;
        return cbit(c, 16) ? ff_m[c] : lut;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        ff_m[0]  = 1'b0;
        ff_m[1]  = 1'b0;
        prev_en  = 1'b0;
    endtask

    task automatic model_clock(bit en, bit din, logic [3:0] in, bit ce, bit sr);
        bit b_in;
        b_in = cbit(0, 17);
        if (en) begin
            q0.push_front(din);
            q1.push_front(b_in);
            if (q0.size() > NBITS) void'(q0.pop_back());
            if (q1.size() > NBITS) void'(q1.pop_back());
            cnt_m[0]++;
            cnt_m[1]++;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (prev_en || sr) ff_m[c] = cbit(c, 17);
                else if (ce)       ff_m[c] = cbit(c, int'(in));
            end
        end
        prev_en = en;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("a_out",  int'(a_out),  int'(e.o0));
            check("a_done", int'(a_done), int'(e.d0));
            check("a_dout", int'(a_dout), int'(e.c0));
            check("b_out",  int'(b_out),  int'(e.o1));
            check("b_done", int'(b_done), int'(e.d1));
            check("b_dout", int'(b_dout), int'(e.c1));
        end
    end

    // Called at posedge+1: drive, queue the expectation, then advance over one clock.
    task automatic step(bit en, bit din, logic [3:0] in, bit ce, bit sr);
        exp_t e;
        bit   sr_eff;
`ifdef LOGIC_CELL_SR_EN
        sr_eff = sr;
`else
        sr_eff = 1'b0;
`endif
        cfg_en_i   = en;
        cfg_data_i = din;
        in_i       = in;
        ce_i       = ce;
        sr_i       = sr_eff;
        e.o0 = exp_out(0, in, en);
        e.d0 = (cnt_m[0] >= NBITS);
        e.c0 = cbit(0, 17);
        e.o1 = exp_out(1, in, en);
        e.d1 = (cnt_m[1] >= NBITS);
        e.c1 = cbit(1, 17);
        sb.push_back(e);
        @(posedge clk_i);
        model_clock(en, din, in, ce, sr_eff);
        #1;
    endtask

    task automatic shift_word(logic [17:0] w);
        for (int i = 17; i >= 0; i--) begin
            step(1'b1, w[i], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic run(int n, bit allow_en);
        for (int i = 0; i < n; i++) begin
            step(allow_en && ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_n_i  = 1'b0;
        cfg_en_i = 1'b0;
        ce_i     = 1'b0;
        sr_i     = 1'b0;
        #1;
        check("rst_a_out",  int'(a_out),  0);
        check("rst_a_done", int'(a_done), 0);
        check("rst_a_dout", int'(a_dout), 0);
        check("rst_b_out",  int'(b_out),  0);
        check("rst_b_done", int'(b_done), 0);
        model_reset();
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        clk_run    = 1'b0;
        rst_n_i    = 1'b1;
        in_i       = '0;
        ce_i       = 1'b0;
        cfg_en_i   = 1'b0;
        cfg_data_i = 1'b0;
        sr_i       = 1'b0;
        model_reset();

        // Reset with no clock running.
        #2 rst_n_i = 1'b0;
        #1;
        check("por_out",  int'(a_out),  0);
        check("por_done", int'(a_done), 0);
        check("por_dout", int'(a_dout), 0);
        #2 rst_n_i = 1'b1;
        #1;
        check("por_hold_done", int'(a_done), 0);

        clk_run = 1'b1;
        @(posedge clk_i);
        #1;

        // XOR table, combinational mode.
        shift_word({1'b0, 1'b0, 16'h6996});
        step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);
        run(20, 1'b0);

        // Registered mode with ff_init=1; B now holds the XOR word.
        shift_word({1'b1, 1'b1, 16'h0000});
        step(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
`ifdef LOGIC_CELL_SR_EN
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
`endif

        // Reset from a configured state, then reset mid-shift after 7 bits.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom_range(0, 1)), 4'd0, 1'b0, 1'b0);
        do_reset();
        shift_word({1'b0, 1'b0, 16'h6996});
        run(10, 1'b0);

        // Random configurations with pass-through shifting and mid-run reconfiguration.
        for (int k = 0; k < 15; k++) begin
            shift_word(18'($urandom));
            run(25, 1'b1);
        end

        @(negedge clk_i);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
